// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and widths for the data memory arbiter
package dmem_arb_pkg;

   localparam int ARB_ADDR_W = 32;
   localparam int ARB_DATA_W = 32;
   localparam int ARB_MASK_W = ARB_DATA_W / 8;
   // Wide enough for any STARVE_MAX up to 15
   localparam int STARVE_W   = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BUSY_L,
      ST_BUSY_D,
      ST_DONE_L,
      ST_DONE_D
   } arb_state_e;

   typedef enum logic {
      REQ_LSU,
      REQ_DMA
   } req_id_e;

   typedef struct packed {
      logic                  wr;
      logic [ARB_MASK_W-1:0] mask;
      logic [ARB_ADDR_W-1:0] addr;
      logic [ARB_DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - LSU/DMA winner selection with a saturating starve counter
module dmem_arb_pick
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    arb_i,
   input  logic    lsu_req_i,
   input  logic    dma_req_i,
   output logic    grant_o,
   output req_id_e winner_o
);

   logic [STARVE_W-1:0] cnt_q, cnt_d;
   logic                starved;

   assign starved = (cnt_q == STARVE_W'(STARVE_MAX));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      grant_o  = arb_i & (lsu_req_i | dma_req_i);
      winner_o = (dma_req_i & (~lsu_req_i | starved)) ? REQ_DMA : REQ_LSU;
      cnt_d    = cnt_q;
      // Counter only moves on arbitration cycles; a lone LSU grant also clears it
      if (arb_i) begin
         if (!dma_req_i || winner_o == REQ_DMA) begin
            cnt_d = '0;
         end else if (lsu_req_i && !starved) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory arbiter between LSU and DMA requesters
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                lsu_cs,
   input  logic                lsu_wr,
   input  logic [DATA_W/8-1:0] lsu_mask,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic [DATA_W-1:0]   lsu_wdata,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                lsu_stall,
   input  logic                dma_req,
   input  logic                dma_wr,
   input  logic [DATA_W/8-1:0] dma_mask,
   input  logic [ADDR_W-1:0]   dma_addr,
   input  logic [DATA_W-1:0]   dma_wdata,
   output logic                dma_gnt,
   output logic                dma_done,
   output logic [DATA_W-1:0]   dma_rdata,
   output logic                cs,
   output logic                wr,
   output logic [DATA_W/8-1:0] mask,
   output logic [ADDR_W-1:0]   addr,
   output logic [DATA_W-1:0]   data_wr,
   input  logic [DATA_W-1:0]   data_rd
);

   localparam int MASK_W = DATA_W / 8;
   localparam int LAT_W  = 2;

   arb_state_e        state_q, state_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   mem_req_t          req_q, req_d;
   logic              cs_q, cs_d;
   logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
   logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
   logic              grant;
   req_id_e           winner;
   logic              last_beat;

   dmem_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
      .clk       (clk),
      .rst       (rst),
      .arb_i     (state_q == ST_IDLE),
      .lsu_req_i (lsu_cs),
      .dma_req_i (dma_req),
      .grant_o   (grant),
      .winner_o  (winner)
   );

   assign last_beat = (lat_q == LAT_W'(MEM_LAT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         lat_q       <= '0;
         req_q       <= '0;
         cs_q        <= 1'b0;
         lsu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         req_q       <= req_d;
         cs_q        <= cs_d;
         lsu_rdata_q <= lsu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (grant) state_d = (winner == REQ_DMA) ? ST_BUSY_D : ST_BUSY_L;
         ST_BUSY_L: if (last_beat) state_d = ST_DONE_L;
         ST_BUSY_D: if (last_beat) state_d = ST_DONE_D;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      lat_d       = '0;
      cs_d        = cs_q;
      req_d       = req_q;
      lsu_rdata_d = lsu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (grant) begin
               cs_d = 1'b1;
               if (winner == REQ_DMA) begin
                  req_d.wr    = dma_wr;
                  req_d.mask  = ARB_MASK_W'(dma_mask);
                  req_d.addr  = ARB_ADDR_W'(dma_addr);
                  req_d.wdata = ARB_DATA_W'(dma_wdata);
               end else begin
                  req_d.wr    = lsu_wr;
                  req_d.mask  = ARB_MASK_W'(lsu_mask);
                  req_d.addr  = ARB_ADDR_W'(lsu_addr);
                  req_d.wdata = ARB_DATA_W'(lsu_wdata);
               end
            end
         end
         ST_BUSY_L, ST_BUSY_D: begin
            if (last_beat) begin
               cs_d  = 1'b0;
               req_d = '0;
               // Writes leave the previous read data in place
               if (!req_q.wr) begin
                  if (state_q == ST_BUSY_L) lsu_rdata_d = data_rd;
                  else                      dma_rdata_d = data_rd;
               end
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign cs        = cs_q;
   assign wr        = req_q.wr;
   assign mask      = req_q.mask[MASK_W-1:0];
   assign addr      = req_q.addr[ADDR_W-1:0];
   assign data_wr   = req_q.wdata[DATA_W-1:0];
   assign lsu_rdata = lsu_rdata_q;
   assign dma_rdata = dma_rdata_q;
   assign lsu_stall = lsu_cs & (state_q != ST_DONE_L);
   // Gated by reset so no grant can leak out while the block is held in reset
   assign dma_gnt   = rst & grant & (winner == REQ_DMA);
   assign dma_done  = (state_q == ST_DONE_D);

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline's load/store unit (M stage) and a secondary DMA/debug-loader requester.
- Sequences each access over a configurable memory latency.
- Stalls the pipeline while an LSU access is pending.
- Prevents DMA starvation with a bounded-priority counter.
- Sits between the load/store unit and the data memory; its memory-side outputs drive the data memory directly.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the mask is DATA_W/8 bits.
- MEM_LAT, 2, cycles an access occupies the memory (legal 1..4); data_rd is valid in the last cycle.
- STARVE_MAX, 4, maximum consecutive LSU grants while dma_req is pending before DMA is forced.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- lsu_cs  in  1  LSU access request; held until lsu_stall is low
- lsu_wr  in  1  1=store, 0=load
- lsu_mask  in  4  byte enables
- lsu_addr  in  ADDR_W  byte address
- lsu_wdata  in  DATA_W  store data
- lsu_rdata  out  DATA_W  load data; valid when lsu_cs=1 and lsu_stall=0
- lsu_stall  out  1  hold the pipeline
- dma_req  in  1  DMA request; held until dma_gnt
- dma_wr  in  1  1=write, 0=read
- dma_mask  in  4  byte enables
- dma_addr  in  ADDR_W  byte address
- dma_wdata  in  DATA_W  write data
- dma_gnt  out  1  1-cycle pulse: request accepted; DMA may change its inputs next cycle
- dma_done  out  1  1-cycle pulse: access complete
- dma_rdata  out  DATA_W  read data; valid with dma_done
- cs  out  1  memory chip select
- wr  out  1  memory write
- mask  out  4  memory byte enables
- addr  out  ADDR_W  memory address
- data_wr  out  DATA_W  memory write data
- data_rd  in  DATA_W  memory read data

Behaviour:
- Reset values:
  - State is IDLE; all registered outputs are 0: cs, wr, mask, addr, data_wr, dma_gnt, dma_done, lsu_rdata, dma_rdata.
  - Latency counter and starve counter are 0.
  - lsu_stall = lsu_cs, even while in reset.
- FSM states: IDLE, BUSY_L, BUSY_D, DONE_L, DONE_D.
- IDLE arbitration:
  - LSU only: go to BUSY_L.
  - DMA only: go to BUSY_D and pulse dma_gnt in this cycle.
  - Both requesting: LSU wins unless starve_cnt == STARVE_MAX, in which case DMA wins.
  - Neither requesting: stay in IDLE.
- On grant, the winner's wr/mask/addr/wdata are registered onto the memory port and cs=1 from the next cycle.
- BUSY_x:
  - Lasts exactly MEM_LAT cycles; lat_cnt counts 0..MEM_LAT-1.
  - Memory port outputs are held stable.
  - On the last cycle, capture data_rd into lsu_rdata or dma_rdata. Writes capture nothing, and the rdata registers keep their value.
  - Then go to DONE_x; cs and the other memory port outputs return to 0.
- DONE_L: one cycle with lsu_stall=0, lsu_rdata valid, then IDLE. A new lsu_cs is arbitrated only in IDLE, so the same request is never reissued.
- DONE_D: dma_done=1 for one cycle, then IDLE.
- lsu_stall is combinational: lsu_cs AND state != DONE_L.
- LSU latency: request seen in IDLE at cycle T; cs high T+1..T+MEM_LAT; DONE_L at T+MEM_LAT+1. The stall therefore lasts MEM_LAT+1 cycles.
- Back-to-back: minimum gap between accesses is 2 cycles (DONE then IDLE). A request held over DONE is arbitrated in the following IDLE.
- Starve counter:
  - Increments, saturating at STARVE_MAX, on each LSU grant while dma_req=1.
  - Clears on DMA grant or whenever dma_req=0 in IDLE.
- Protocol violations: dma_req or lsu_cs dropping before completion does not abort an in-flight access. It completes; dma_done still pulses, and the LSU result is discarded.
- Reset mid-access:
  - cs drops asynchronously.
  - Memory write is suppressed from the reset edge.
  - No done or gnt pulses are generated.
  - The requester must re-issue.

Decomposition:
- Package dmem_arb_pkg holds:
  - arb_state_e (5 states)
  - req_id_e (REQ_LSU, REQ_DMA)
  - packed struct mem_req_t {wr, mask, addr, wdata}
  - STARVE_W width localparam
- One sub-module, dmem_arb_pick: winner selection plus the saturating starve counter. It is the only logic with fairness state, so it gets its own unit test.

Test Plan (MEM_LAT=2, STARVE_MAX=4):
1. LSU load: lsu_cs=1, lsu_wr=0, addr=0x10, mem[0x10]=0xDEADBEEF.
   - Required: lsu_stall high 3 cycles; cs high cycles 2-3; lsu_rdata=0xDEADBEEF with stall low in cycle 4.
2. LSU store: mask=4'b0011, wdata=0x0000ABCD, addr=0x20.
   - Required: wr=1, mask=0011 held 2 cycles.
   - A later load of 0x20 returns low half 0xABCD.
3. DMA write then read at 0x40=0x12345678 with lsu_cs=0.
   - Required: dma_gnt in the accepting cycle; dma_done 3 cycles later; the read returns 0x12345678.
4. Contention: lsu_cs held high continuously with new addresses, dma_req high.
   - Required: exactly 4 LSU accesses complete, then the 5th grant goes to DMA; the starve counter returns to 0.
5. Simultaneous requests with starve_cnt=0.
   - Required: LSU wins; dma_gnt only after DONE_L + IDLE (cycle T+4).
6. Async reset asserted during the 2nd cs cycle of a DMA write to 0x80.
   - Required: cs=0 immediately; no dma_done; mem[0x80] unchanged.
   - After release, all outputs are 0 and lsu_stall equals lsu_cs.
